// File: rtl/pio_pkg.sv
// +-----------------------------------------------------------------------+
// | pio_pkg : register map and bus constants shared by the PIO blocks     |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
`default_nettype none

package pio_pkg;

  typedef logic [1:0] pio_addr_t;

  localparam int        PIO_BUS_W        = 32;
  localparam pio_addr_t PIO_ADDR_DATA    = 2'd0;
  localparam pio_addr_t PIO_ADDR_RSVD    = 2'd1;
  localparam pio_addr_t PIO_ADDR_IRQMASK = 2'd2;
  localparam pio_addr_t PIO_ADDR_EDGECAP = 2'd3;

  // Arm counter terminal value; edge capture is enabled only here.
  localparam logic [1:0] PIO_ARM_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// +-----------------------------------------------------------------------+
// | key_debounce : per-bit debouncer, state follows input after it has    |
// |                been stable for DEBOUNCE_CYCLES cycles                 |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic d_sync,
  output logic q
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (d_sync == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      state_d = d_sync;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

`default_nettype wire

// File: rtl/key_input_pio.sv
// +-----------------------------------------------------------------------+
// | key_input_pio : memory-mapped key/switch input port with rising-edge  |
// |                 capture and masked level irq. Define DEBOUNCE_EN to   |
// |                 insert a key_debounce per bit after the synchroniser. |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
`default_nettype none

module key_input_pio
  import pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [PIO_BUS_W-1:0] writedata,
  input  logic [WIDTH-1:0]     in_port,
  output logic [PIO_BUS_W-1:0] readdata,
  output logic                 irq
);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [1:0]       arm_q, arm_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic [WIDTH-1:0] rd_val;
  logic             unused_wdata;

  // Only the low WIDTH bits of the write bus carry register data.
  assign unused_wdata = ^writedata;

`ifdef DEBOUNCE_EN
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk    (clk),
      .reset  (reset),
      .d_sync (sync2_q[gi]),
      .q      (level[gi])
    );
  end
`else
  assign level = sync2_q;
`endif

  assign wr_en = chipselect & ~write_n;
  assign rise  = (arm_q == PIO_ARM_DONE) ? (level & ~prev_q) : '0;

  always_comb begin
    arm_d     = arm_q;
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (arm_q != PIO_ARM_DONE) begin
      arm_d = arm_q + 2'd1;
    end
    if (wr_en && address == PIO_ADDR_IRQMASK) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && address == PIO_ADDR_EDGECAP) begin
      edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    end
    // A fresh edge overrides a simultaneous clear of the same bit.
    edgecap_d = edgecap_d | rise;
    irq_d     = |(edgecap_q & irqmask_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      arm_q     <= 2'd0;
      irqmask_q <= '0;
      edgecap_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      sync1_q   <= in_port;
      sync2_q   <= sync1_q;
      prev_q    <= level;
      arm_q     <= arm_d;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    rd_val = '0;
    if (chipselect) begin
      case (address)
        PIO_ADDR_DATA:    rd_val = level;
        PIO_ADDR_IRQMASK: rd_val = irqmask_q;
        PIO_ADDR_EDGECAP: rd_val = edgecap_q;
        default:          rd_val = '0;
      endcase
    end
    readdata              = '0;
    readdata[WIDTH-1:0]   = rd_val;
  end

  assign irq = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_key_input_pio.sv
// +-----------------------------------------------------------------------+
// | tb_key_input_pio : directed self-checking bench for key_input_pio     |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_key_input_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  key_input_pio #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    address    = a;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    chk(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'h0;
    tick(3);
    reset = 1'b0;
    tick(1);

    chk("reset_irq", {31'd0, irq}, 32'd0);
    read_chk("reset_data", 2'd0, 32'd0);
    read_chk("reset_rsvd", 2'd1, 32'd0);
    read_chk("reset_mask", 2'd2, 32'd0);
    read_chk("reset_ecap", 2'd3, 32'd0);
    chipselect = 1'b0;
    address    = 2'd0;
    #1;
    chk("nocs_read", readdata, 32'd0);
    tick(4);

`ifdef DEBOUNCE_EN
    // Short glitch on bit 1 must be filtered.
    in_port = 4'b0010;
    tick(5);
    in_port = 4'b0000;
    tick(15);
    read_chk("glitch_data", 2'd0, 32'd0);
    read_chk("glitch_ecap", 2'd3, 32'd0);

    // Stable high: 2 sync + 8 count + 1 load = 11 edges.
    in_port = 4'b0010;
    tick(10);
    read_chk("deb_data_early", 2'd0, 32'd0);
    tick(1);
    read_chk("deb_data_set", 2'd0, 32'h2);
    tick(2);
    read_chk("deb_ecap", 2'd3, 32'h2);
    bus_write(2'd2, 32'h2);
    tick(2);
    chk("deb_irq", {31'd0, irq}, 32'd1);
`else
    // Inputs held high across reset release must not be captured.
    reset   = 1'b1;
    in_port = 4'hF;
    tick(2);
    reset = 1'b0;
    tick(6);
    read_chk("hold_ecap", 2'd3, 32'd0);
    read_chk("hold_data", 2'd0, 32'hF);
    chk("hold_irq", {31'd0, irq}, 32'd0);
    in_port = 4'h0;
    tick(4);

    // Rise on bit 0: edgecap after 3 edges, irq after 4.
    bus_write(2'd2, 32'h1);
    read_chk("mask_rd", 2'd2, 32'h1);
    in_port = 4'b0001;
    tick(3);
    chk("lat3_irq", {31'd0, irq}, 32'd0);
    read_chk("lat3_ecap", 2'd3, 32'h1);
    tick(1);
    chk("lat4_irq", {31'd0, irq}, 32'd1);

    // W1C clears edgecap at once; irq follows one cycle later.
    bus_write(2'd3, 32'h1);
    read_chk("w1c_ecap", 2'd3, 32'h0);
    chk("w1c_irq_hold", {31'd0, irq}, 32'd1);
    tick(1);
    chk("w1c_irq_drop", {31'd0, irq}, 32'd0);

    // Bits 0 and 2 rise together.
    in_port = 4'b0000;
    tick(3);
    in_port = 4'b0101;
    tick(3);
    read_chk("two_rise_ecap", 2'd3, 32'h5);

    // Re-rise bit 2 exactly while it is being cleared: set wins.
    in_port = 4'b0001;
    tick(3);
    in_port = 4'b0101;
    tick(2);
    bus_write(2'd3, 32'h4);
    read_chk("set_wins_ecap", 2'd3, 32'h5);
    bus_write(2'd3, 32'h2);
    read_chk("w1c_other_ecap", 2'd3, 32'h5);

    // DATA and reserved address ignore writes.
    bus_write(2'd0, 32'hA);
    read_chk("data_ro", 2'd0, 32'h5);
    bus_write(2'd1, 32'hF);
    read_chk("rsvd_ro", 2'd1, 32'h0);
    bus_write(2'd2, 32'hFFFF_FFFF);
    read_chk("mask_trunc", 2'd2, 32'hF);

    // Build edgecap = 0x3 with irq set, for the reset test.
    bus_write(2'd3, 32'hF);
    in_port = 4'b0000;
    tick(3);
    read_chk("clear_all_ecap", 2'd3, 32'h0);
    in_port = 4'b0011;
    tick(4);
    read_chk("pre_rst_ecap", 2'd3, 32'h3);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
`endif

    // Asynchronous reset mid-cycle: irq must fall without a clock edge.
    #1;
    reset = 1'b1;
    #1;
    chk("arst_irq", {31'd0, irq}, 32'd0);
    read_chk("arst_data", 2'd0, 32'd0);
    read_chk("arst_mask", 2'd2, 32'd0);
    read_chk("arst_ecap", 2'd3, 32'd0);
    tick(2);
    reset   = 1'b0;
    in_port = 4'h0;
    tick(2);
    bus_read(2'd1, d);
    chk("post_rst_rsvd", d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
